axi4_lite_slave_rw_scheduler: RTL and testbench



---
 rtl/axi4_lite_slave_rw_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_axi4_lite_slave_rw_scheduler.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_slave_rw_scheduler.sv
// AXI4-Lite slave responder: one single-port register bank shared by the write and read
// channel groups. Each transfer waits a programmable delay, then arbitrates round-robin for the bank.
module axi4_lite_slave_rw_scheduler #(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       DATA_WIDTH    = 32,
    parameter int                       DELAY_WIDTH   = 5,
    parameter int                       MEM_DEPTH     = 16,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = '0,
    parameter bit                       SECURE_ONLY   = 1'b0
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [ADDRESS_WIDTH-1:0]  awaddr,
    input  logic [2:0]                awprot,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH/8-1:0]   wstrb,
    input  logic                      wvalid,
    output logic                      wready,
    output logic [1:0]                bresp,
    output logic                      bvalid,
    input  logic                      bready,
    input  logic [ADDRESS_WIDTH-1:0]  araddr,
    input  logic [2:0]                arprot,
    input  logic                      arvalid,
    output logic                      arready,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic [1:0]                rresp,
    output logic                      rvalid,
    input  logic                      rready,
    input  logic [DELAY_WIDTH-1:0]    readyDelay
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int ADDR_LSB   = $clog2(STRB_WIDTH);
    localparam int IDX_W      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DELAY  = 3'd1;
    localparam logic [2:0] ST_REQ    = 3'd2;
    localparam logic [2:0] ST_ACCEPT = 3'd3;
    localparam logic [2:0] ST_RESP   = 3'd4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [2:0]             wr_state, rd_state;
    logic [DELAY_WIDTH-1:0] wr_count, rd_count;
    logic                   rr_ptr;
    logic                   wr_req, rd_req, wr_grant, rd_grant;
    logic                   wr_ok, rd_ok;
    logic [IDX_W-1:0]       wr_idx, rd_idx;
    logic [DATA_WIDTH-1:0]  bank [MEM_DEPTH];
    logic                   unused_prot;

    function automatic logic decode_ok(input logic [ADDRESS_WIDTH-1:0] addr, input logic nonsecure);
        logic [ADDRESS_WIDTH-1:0] offset;
        offset    = addr - BASE_ADDR;
        decode_ok = (addr >= BASE_ADDR) &&
                    ((offset >> ADDR_LSB) < ADDRESS_WIDTH'(MEM_DEPTH)) &&
                    !(SECURE_ONLY && nonsecure);
    endfunction

    function automatic logic [IDX_W-1:0] decode_index(input logic [ADDRESS_WIDTH-1:0] addr);
        logic [ADDRESS_WIDTH-1:0] offset;
        offset       = addr - BASE_ADDR;
        decode_index = IDX_W'(offset >> ADDR_LSB);
    endfunction

    assign wr_ok       = decode_ok(awaddr, awprot[1]);
    assign rd_ok       = decode_ok(araddr, arprot[1]);
    assign wr_idx      = decode_index(awaddr);
    assign rd_idx      = decode_index(araddr);
    assign unused_prot = ^{awprot[2], awprot[0], arprot[2], arprot[0]};

    assign awready = (wr_state == ST_ACCEPT);
    assign wready  = (wr_state == ST_ACCEPT);
    assign bvalid  = (wr_state == ST_RESP);
    assign arready = (rd_state == ST_ACCEPT);
    assign rvalid  = (rd_state == ST_RESP);

    // Requests drop out as soon as the master withdraws valid, so a grant never lands on a stale request.
    assign wr_req = (wr_state == ST_REQ) && awvalid && wvalid;
    assign rd_req = (rd_state == ST_REQ) && arvalid;

    always_comb begin
        wr_grant = 1'b0;
        rd_grant = 1'b0;
        if (wr_req && (!rd_req || !rr_ptr)) begin
            wr_grant = 1'b1;
        end else if (rd_req) begin
            rd_grant = 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rr_ptr <= 1'b0;
        end else if (wr_grant) begin
            rr_ptr <= 1'b1;
        end else if (rd_grant) begin
            rr_ptr <= 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_state <= ST_IDLE;
            wr_count <= '0;
            bresp    <= RESP_OKAY;
        end else begin
            case (wr_state)
                ST_IDLE: if (awvalid && wvalid) begin
                    if (readyDelay != '0) begin
                        wr_state <= ST_DELAY;
                        wr_count <= readyDelay;
                    end else begin
                        wr_state <= ST_REQ;
                    end
                end
                ST_DELAY: begin
                    if (!(awvalid && wvalid))            wr_state <= ST_IDLE;
                    else if (wr_count == DELAY_WIDTH'(1)) wr_state <= ST_REQ;
                    else                                  wr_count <= wr_count - 1'b1;
                end
                ST_REQ: begin
                    if (!(awvalid && wvalid)) wr_state <= ST_IDLE;
                    else if (wr_grant)        wr_state <= ST_ACCEPT;
                end
                ST_ACCEPT: begin
                    wr_state <= ST_RESP;
                    bresp    <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                end
                ST_RESP: if (bready) wr_state <= ST_IDLE;
                default: wr_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_state <= ST_IDLE;
            rd_count <= '0;
            rdata    <= '0;
            rresp    <= RESP_OKAY;
        end else begin
            case (rd_state)
                ST_IDLE: if (arvalid) begin
                    if (readyDelay != '0) begin
                        rd_state <= ST_DELAY;
                        rd_count <= readyDelay;
                    end else begin
                        rd_state <= ST_REQ;
                    end
                end
                ST_DELAY: begin
                    if (!arvalid)                         rd_state <= ST_IDLE;
                    else if (rd_count == DELAY_WIDTH'(1)) rd_state <= ST_REQ;
                    else                                  rd_count <= rd_count - 1'b1;
                end
                ST_REQ: begin
                    if (!arvalid)      rd_state <= ST_IDLE;
                    else if (rd_grant) rd_state <= ST_ACCEPT;
                end
                ST_ACCEPT: begin
                    rd_state <= ST_RESP;
                    rdata    <= rd_ok ? bank[rd_idx] : '0;
                    rresp    <= rd_ok ? RESP_OKAY : RESP_SLVERR;
                end
                ST_RESP: if (rready) rd_state <= ST_IDLE;
                default: rd_state <= ST_IDLE;
            endcase
        end
    end

    // Only one side can be in ACCEPT at a time, so the bank never sees a read and write together.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                bank[i] <= '0;
            end
        end else if (wr_state == ST_ACCEPT && wr_ok) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (wstrb[b]) begin
                    bank[wr_idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_axi4_lite_slave_rw_scheduler.sv
// Directed bench for axi4_lite_slave_rw_scheduler: latency, strobes, arbitration,
// decode errors, B back-pressure and reset abort, with hand-computed expectations.
module tb_axi4_lite_slave_rw_scheduler;

    logic        aclk;
    logic        aresetn;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic [4:0]  readyDelay;

    int tests_run    = 0;
    int tests_failed = 0;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    axi4_lite_slave_rw_scheduler #(
        .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .DELAY_WIDTH(5),
        .MEM_DEPTH(16), .BASE_ADDR(32'h0), .SECURE_ONLY(1'b1)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .readyDelay(readyDelay)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Valids rise in cycle 0: readies expected in cycle 2+D, response in cycle 3+D.
    task automatic write_txn(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int delay, input logic [1:0] exp_resp);
        awaddr = addr; wdata = data; wstrb = strb; awprot = 3'b000;
        readyDelay = 5'(delay); awvalid = 1'b1; wvalid = 1'b1;
        repeat (delay + 1) tick();
        check_output("wr_ready_early", {awready, wready}, 2'b00);
        tick();
        check_output("wr_ready", {awready, wready}, 2'b11);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        check_output("wr_bvalid", bvalid, 1'b1);
        check_output("wr_bresp", bresp, exp_resp);
        bready = 1'b1;
        tick();
        check_output("wr_bvalid_clear", bvalid, 1'b0);
        bready = 1'b0;
    endtask

    task automatic read_txn(input logic [31:0] addr, input logic [2:0] prot, input int delay,
                            input logic [31:0] exp_data, input logic [1:0] exp_resp);
        araddr = addr; arprot = prot; readyDelay = 5'(delay); arvalid = 1'b1;
        repeat (delay + 1) tick();
        check_output("rd_ready_early", arready, 1'b0);
        tick();
        check_output("rd_ready", arready, 1'b1);
        tick();
        arvalid = 1'b0;
        check_output("rd_rvalid", rvalid, 1'b1);
        check_output("rd_rdata", rdata, exp_data);
        check_output("rd_rresp", rresp, exp_resp);
        rready = 1'b1;
        tick();
        check_output("rd_rvalid_clear", rvalid, 1'b0);
        rready = 1'b0;
    endtask

    initial begin
        aresetn = 1'b0;
        awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0; readyDelay = '0;
        repeat (2) tick();
        check_output("rst_readies", {awready, wready, arready}, 3'b000);
        check_output("rst_valids", {bvalid, rvalid}, 2'b00);
        check_output("rst_resps", {bresp, rresp}, 4'h0);
        check_output("rst_rdata", rdata, 32'h0);
        aresetn = 1'b1;
        tick();

        // Basic write/read with no delay, then a strobed overwrite with D=5.
        write_txn(32'h4, 32'hDEADBEEF, 4'hF, 0, OKAY);
        read_txn(32'h4, 3'b000, 0, 32'hDEADBEEF, OKAY);
        write_txn(32'h8, 32'h11223344, 4'hF, 5, OKAY);
        write_txn(32'h8, 32'hAAAAAAAA, 4'h2, 5, OKAY);
        read_txn(32'h8, 3'b000, 0, 32'h1122AA44, OKAY);

        // Contention with pointer on write: write first, read sees the new word.
        awaddr = 32'hC; wdata = 32'h55667788; wstrb = 4'hF; readyDelay = '0;
        araddr = 32'hC; arprot = 3'b000;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        tick();
        tick();
        check_output("c1_wr_first", {awready, arready}, 2'b10);
        tick();
        check_output("c1_rd_second", {awready, arready}, 2'b01);
        check_output("c1_bvalid", bvalid, 1'b1);
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        tick();
        arvalid = 1'b0; bready = 1'b0;
        check_output("c1_bvalid_clear", bvalid, 1'b0);
        check_output("c1_rvalid", rvalid, 1'b1);
        check_output("c1_rdata", rdata, 32'h55667788);
        rready = 1'b1;
        tick();
        rready = 1'b0;

        // Out-of-range accesses; the SLVERR write leaves the pointer on read.
        read_txn(32'h40, 3'b000, 0, 32'h0, SLVERR);
        write_txn(32'h40, 32'h12345678, 4'hF, 0, SLVERR);

        // Contention with pointer on read: read first returns bank[0] untouched by the bad write.
        awaddr = 32'h0; wdata = 32'hCAFEF00D; wstrb = 4'hF; araddr = 32'h0;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        tick();
        tick();
        check_output("c2_rd_first", {awready, arready}, 2'b01);
        tick();
        check_output("c2_wr_second", {awready, arready}, 2'b10);
        check_output("c2_rvalid", rvalid, 1'b1);
        check_output("c2_rdata_old", rdata, 32'h0);
        arvalid = 1'b0; rready = 1'b1;
        tick();
        rready = 1'b0;
        check_output("c2_bvalid", bvalid, 1'b1);
        check_output("c2_bresp", bresp, OKAY);
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        tick();
        bready = 1'b0;
        read_txn(32'h0, 3'b000, 0, 32'hCAFEF00D, OKAY);

        // Non-secure access is rejected in this configuration.
        read_txn(32'h4, 3'b010, 0, 32'h0, SLVERR);

        // B back-pressure: response held, second write not accepted until the B handshake.
        awaddr = 32'h10; wdata = 32'h0BADF00D; wstrb = 4'hF; readyDelay = '0;
        awvalid = 1'b1; wvalid = 1'b1;
        repeat (3) tick();
        awaddr = 32'h14; wdata = 32'h13572468;
        for (int i = 0; i < 4; i++) begin
            check_output("bp_bvalid", bvalid, 1'b1);
            check_output("bp_bresp", bresp, OKAY);
            check_output("bp_wready", wready, 1'b0);
            if (i < 3) tick();
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check_output("bp_bvalid_clear", bvalid, 1'b0);
        check_output("bp_wready_after", wready, 1'b0);
        tick();
        tick();
        check_output("bp_second_ready", wready, 1'b1);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        check_output("bp_second_bvalid", bvalid, 1'b1);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        read_txn(32'h14, 3'b000, 0, 32'h13572468, OKAY);

        // Reset during the delay phase aborts the write and clears the bank.
        awaddr = 32'h0; wdata = 32'hFFFFFFFF; wstrb = 4'hF; readyDelay = 5'd10;
        awvalid = 1'b1; wvalid = 1'b1;
        repeat (3) tick();
        aresetn = 1'b0;
        #1;
        check_output("arst_outputs", {awready, wready, arready, bvalid, rvalid}, 5'b0);
        check_output("arst_rdata", rdata, 32'h0);
        awvalid = 1'b0; wvalid = 1'b0; readyDelay = '0;
        tick();
        aresetn = 1'b1;
        tick();
        read_txn(32'h0, 3'b000, 0, 32'h0, OKAY);
        read_txn(32'h4, 3'b000, 0, 32'h0, OKAY);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
